// File: rtl/uart_pwm_controller_if.sv
// Byte-level handshake between the UART receiver/transmitter and the PWM controller.
// The controller takes the slave modport; the UART side (or a bench) takes master.
interface uart_pwm_controller_if;
    logic [7:0] rcv_data;
    logic       rcv_ready;
    logic       snd_busy;
    logic [7:0] snd_data;
    logic       snd_ready;

    modport master (
        output rcv_data, rcv_ready, snd_busy,
        input  snd_data, snd_ready
    );

    modport slave (
        input  rcv_data, rcv_ready, snd_busy,
        output snd_data, snd_ready
    );
endinterface

// File: rtl/uart_pwm_controller.sv
// UART command parser ('S' ch duty / 'G' ch) driving NUM_CHANNELS glitch-free PWM outputs.
// Optional macro UART_PWM_CMD_TIMEOUT_EN abandons a partial command after TIMEOUT_CYCLES idle cycles.
module uart_pwm_controller #(
    parameter int NUM_CHANNELS   = 3,
    parameter int PRESCALE       = 187,
    parameter int TIMEOUT_CYCLES = 4_800_000
) (
    input  logic                    clk,
    input  logic                    reset,
    uart_pwm_controller_if.slave    bus,
    output logic [NUM_CHANNELS-1:0] pwm
);

    localparam logic [7:0] CMD_SET  = 8'h53;
    localparam logic [7:0] CMD_GET  = 8'h47;
    localparam logic [7:0] RESP_ERR = 8'h45;
    localparam logic [7:0] RESP_OK  = 8'h4B;
    localparam int         PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [2:0] {
        IDLE,
        GET_CH,
        GET_DUTY,
        RESP_WAIT,
        RESP_SEND
    } state_t;

    state_t      state, state_next;
    logic        is_set, is_set_next;
    logic [2:0]  ch_reg, ch_next;
    logic [7:0]  resp_byte, resp_next;
    logic [7:0]  snd_data_q;
    logic        duty_we;
    logic        timed_out;

    logic [PW-1:0] presc;
    logic          presc_tick;
    logic [7:0]    phase;
    logic          phase_wrap;

    // Duty storage is sized for the 8-channel maximum so a 3-bit channel index never overruns.
    logic [7:0] pending_duty [8];
    logic [7:0] pending_next [8];
    logic [7:0] active_duty  [8];

    assign bus.snd_ready = (state == RESP_SEND);
    assign bus.snd_data  = snd_data_q;

`ifdef UART_PWM_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
        end else if (bus.rcv_ready || !(state == GET_CH || state == GET_DUTY)) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign timed_out = (idle_cnt == TW'(TIMEOUT_CYCLES));
`else
    assign timed_out = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            is_set     <= 1'b0;
            ch_reg     <= '0;
            resp_byte  <= '0;
            snd_data_q <= '0;
        end else begin
            state     <= state_next;
            is_set    <= is_set_next;
            ch_reg    <= ch_next;
            resp_byte <= resp_next;
            if (state == RESP_WAIT && !bus.snd_busy) begin
                snd_data_q <= resp_byte;
            end
        end
    end

    always_comb begin
        state_next  = state;
        is_set_next = is_set;
        ch_next     = ch_reg;
        resp_next   = resp_byte;
        duty_we     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.rcv_ready) begin
                    if (bus.rcv_data == CMD_SET || bus.rcv_data == CMD_GET) begin
                        is_set_next = (bus.rcv_data == CMD_SET);
                        state_next  = GET_CH;
                    end else begin
                        resp_next  = RESP_ERR;
                        state_next = RESP_WAIT;
                    end
                end
            end
            GET_CH: begin
                if (bus.rcv_ready) begin
                    if (bus.rcv_data >= 8'(NUM_CHANNELS)) begin
                        resp_next  = RESP_ERR;
                        state_next = RESP_WAIT;
                    end else if (is_set) begin
                        ch_next    = bus.rcv_data[2:0];
                        state_next = GET_DUTY;
                    end else begin
                        resp_next  = active_duty[bus.rcv_data[2:0]];
                        state_next = RESP_WAIT;
                    end
                end else if (timed_out) begin
                    state_next = IDLE;
                end
            end
            GET_DUTY: begin
                if (bus.rcv_ready) begin
                    duty_we    = 1'b1;
                    resp_next  = RESP_OK;
                    state_next = RESP_WAIT;
                end else if (timed_out) begin
                    state_next = IDLE;
                end
            end
            RESP_WAIT: begin
                if (!bus.snd_busy) begin
                    state_next = RESP_SEND;
                end
            end
            RESP_SEND: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign presc_tick = (presc == PW'(PRESCALE - 1));
    assign phase_wrap = presc_tick && (phase == 8'hFF);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
            phase <= '0;
        end else if (presc_tick) begin
            presc <= '0;
            phase <= phase + 8'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // A write landing on the wrap cycle must reach the active register at that same wrap.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            pending_next[i] = pending_duty[i];
            if (duty_we && ch_reg == 3'(i)) begin
                pending_next[i] = bus.rcv_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                pending_duty[i] <= '0;
                active_duty[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                pending_duty[i] <= pending_next[i];
                if (phase_wrap) begin
                    active_duty[i] <= pending_next[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm <= '0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                pwm[i] <= (phase < active_duty[i]);
            end
        end
    end

endmodule

// File: tb/tb_uart_pwm_controller.sv
// Directed bench for uart_pwm_controller: command table plus hand sequences for PWM timing,
// transmitter back-pressure, reset and the optional UART_PWM_CMD_TIMEOUT_EN behaviour.
module tb_uart_pwm_controller;

    localparam int NCH    = 3;
    localparam int PRE    = 2;
    localparam int TMO    = 50;
    localparam int PERIOD = 256 * PRE;

    logic           clk = 1'b0;
    logic           reset;
    logic [NCH-1:0] pwm;

    uart_pwm_controller_if bus_if ();

    uart_pwm_controller #(
        .NUM_CHANNELS   (NCH),
        .PRESCALE       (PRE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave),
        .pwm   (pwm)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [1:0] n;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [12];
    int   vectors     = 0;
    int   miscompares = 0;
    int   ready_cnt   = 0;

    always @(negedge clk) begin
        if (bus_if.snd_ready === 1'b1) ready_cnt++;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus_if.rcv_data  = b;
        bus_if.rcv_ready = 1'b1;
        @(negedge clk);
        bus_if.rcv_ready = 1'b0;
    endtask

    task automatic expect_response(input string name, input logic [7:0] exp, input int exp_lat);
        int lat;
        lat = 0;
        while (bus_if.snd_ready !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (bus_if.snd_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s_timeout: no snd_ready within %0d cycles, expected one pulse", name, lat);
        end else begin
            check_output({name, "_lat"}, 32'(lat), 32'(exp_lat));
            check_output({name, "_data"}, 32'(bus_if.snd_data), 32'(exp));
            @(negedge clk);
            check_output({name, "_pulse"}, 32'(bus_if.snd_ready), 32'd0);
            check_output({name, "_hold"}, 32'(bus_if.snd_data), 32'(exp));
        end
    endtask

    task automatic expect_silence(input string name, input int cycles);
        int s;
        #1;
        s = ready_cnt;
        repeat (cycles) @(negedge clk);
        #1;
        check_output(name, 32'(ready_cnt - s), 32'd0);
    endtask

    task automatic apply_stimulus(input vec_t v, input int idx);
        send_byte(v.b0);
        if (v.n > 2'd1) send_byte(v.b1);
        if (v.n > 2'd2) send_byte(v.b2);
        expect_response($sformatf("vec%0d", idx), v.exp, 1);
    endtask

    initial begin
        int h0, h1, l2, run, k, any_hi, s;
        logic prev;
        logic found;

        reset            = 1'b0;
        bus_if.rcv_data  = '0;
        bus_if.rcv_ready = 1'b0;
        bus_if.snd_busy  = 1'b0;

        vecs[0]  = '{8'h53, 8'h01, 8'h80, 2'd3, 8'h4B};
        vecs[1]  = '{8'h53, 8'h00, 8'h00, 2'd3, 8'h4B};
        vecs[2]  = '{8'h53, 8'h02, 8'hFF, 2'd3, 8'h4B};
        vecs[3]  = '{8'h58, 8'h00, 8'h00, 2'd1, 8'h45};
        vecs[4]  = '{8'h47, 8'h05, 8'h00, 2'd2, 8'h45};
        vecs[5]  = '{8'h47, 8'h03, 8'h00, 2'd2, 8'h45};
        vecs[6]  = '{8'h00, 8'h00, 8'h00, 2'd1, 8'h45};
        vecs[7]  = '{8'h53, 8'h03, 8'h00, 2'd2, 8'h45};
        vecs[8]  = '{8'h10, 8'h00, 8'h00, 2'd1, 8'h45};
        vecs[9]  = '{8'h47, 8'h01, 8'h00, 2'd2, 8'h80};
        vecs[10] = '{8'h47, 8'h00, 8'h00, 2'd2, 8'h00};
        vecs[11] = '{8'h47, 8'h02, 8'h00, 2'd2, 8'hFF};

        repeat (3) @(negedge clk);
        check_output("rst_snd_ready", 32'(bus_if.snd_ready), 32'd0);
        check_output("rst_snd_data", 32'(bus_if.snd_data), 32'd0);
        check_output("rst_pwm", 32'(pwm), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i <= 8; i++) apply_stimulus(vecs[i], i);

        // Let the new duties reach the active registers, then measure one full period.
        repeat (PERIOD + 100) @(negedge clk);
        h0 = 0; h1 = 0; l2 = 0;
        repeat (PERIOD) begin
            @(negedge clk);
            h0 += int'(pwm[0]);
            h1 += int'(pwm[1]);
            l2 += int'(!pwm[2]);
        end
        check_output("duty80_highs", 32'(h1), 32'(128 * PRE));
        check_output("duty00_highs", 32'(h0), 32'd0);
        check_output("dutyFF_lows", 32'(l2), 32'(PRE));

        for (int i = 9; i <= 11; i++) apply_stimulus(vecs[i], i);

        // Synchronise to a phase wrap via the rising edge of pwm[1].
        prev = pwm[1]; found = 1'b0; k = 0;
        while (!found && k < 3 * PERIOD) begin
            @(negedge clk);
            k++;
            if (!prev && pwm[1]) found = 1'b1;
            prev = pwm[1];
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL pwm1_rise: no rising edge in %0d cycles, expected one per period", k);
        end else begin
            run = 0;
            while (pwm[1] === 1'b1 && run < PERIOD) begin
                run++;
                @(negedge clk);
            end
            check_output("pwm1_run", 32'(run), 32'(128 * PRE));
        end

        send_byte(8'h53); send_byte(8'h00); send_byte(8'h33);
        expect_response("set_ch0_33", 8'h4B, 1);
        send_byte(8'h47); send_byte(8'h00);
        expect_response("get_active_old", 8'h00, 1);
        repeat (PERIOD + 50) @(negedge clk);
        send_byte(8'h47); send_byte(8'h00);
        expect_response("get_active_new", 8'h33, 1);
        h0 = 0;
        repeat (PERIOD) begin
            @(negedge clk);
            h0 += int'(pwm[0]);
        end
        check_output("duty33_highs", 32'(h0), 32'(8'h33 * PRE));

        // Back-pressure: response held while busy; a byte arriving meanwhile is dropped.
        @(negedge clk);
        bus_if.snd_busy = 1'b1;
        #1;
        s = ready_cnt;
        send_byte(8'h47); send_byte(8'h01);
        repeat (40) @(negedge clk);
        send_byte(8'h58);
        repeat (56) @(negedge clk);
        #1;
        check_output("busy_hold", 32'(ready_cnt - s), 32'd0);
        @(negedge clk);
        bus_if.snd_busy = 1'b0;
        expect_response("busy_release", 8'h80, 1);
        expect_silence("busy_discard", 30);

        // Reset in the middle of an 'S' command.
        send_byte(8'h53); send_byte(8'h01);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_output("midcmd_rst_snd_data", 32'(bus_if.snd_data), 32'd0);
        check_output("midcmd_rst_snd_ready", 32'(bus_if.snd_ready), 32'd0);
        check_output("midcmd_rst_pwm", 32'(pwm), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        send_byte(8'h80);
        expect_response("post_rst_fresh", 8'h45, 1);
        send_byte(8'h47); send_byte(8'h02);
        expect_response("post_rst_duty2", 8'h00, 1);
        any_hi = 0;
        repeat (PERIOD) begin
            @(negedge clk);
            if (pwm != '0) any_hi++;
        end
        check_output("post_rst_pwm_low", 32'(any_hi), 32'd0);

        // Reset while a response is queued behind a busy transmitter.
        @(negedge clk);
        bus_if.snd_busy = 1'b1;
        send_byte(8'h58);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        bus_if.snd_busy = 1'b0;
        expect_silence("rst_drops_resp", 20);

`ifdef UART_PWM_CMD_TIMEOUT_EN
        send_byte(8'h53);
        expect_silence("timeout_quiet", 60);
        send_byte(8'h47); send_byte(8'h00);
        expect_response("timeout_get0", 8'h00, 1);
        expect_silence("timeout_single", 20);
`else
        send_byte(8'h53);
        expect_silence("no_timeout_quiet", 60);
        send_byte(8'h01); send_byte(8'h22);
        expect_response("late_duty", 8'h4B, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_pwm_controller.md
UART_PWM_CONTROLLER -- requirements
Module: uart_pwm_controller

Interface
REQ-001 The block SHALL have parameter NUM_CHANNELS, default 3, meaning the number of PWM outputs (legal range 1..8).
REQ-002 The block SHALL have parameter PRESCALE, default 187, meaning system-clock cycles per PWM phase step (minimum 1).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 4_800_000, meaning the idle cycles before a partial command is abandoned.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port rcv_data, input, 8 bits: received byte, valid while rcv_ready is high.
REQ-007 The block SHALL have port rcv_ready, input, 1 bit: one-cycle pulse marking a received byte.
REQ-008 The block SHALL have port snd_busy, input, 1 bit: the transmitter is sending.
REQ-009 The block SHALL have port snd_data, output, 8 bits: response byte, held stable until the next send.
REQ-010 The block SHALL have port snd_ready, output, 1 bit: one-cycle send request.
REQ-011 The block SHALL have port pwm, output, NUM_CHANNELS bits: PWM outputs; bit i is channel i.

Function
REQ-012 The command protocol SHALL be: 'S'(0x53), ch, duty sets a duty; 'G'(0x47), ch reads a duty; ch is binary 0..NUM_CHANNELS-1.
REQ-013 The parser FSM SHALL use the states IDLE, GET_CH, GET_DUTY, RESP_WAIT and RESP_SEND.
REQ-014 IDLE SHALL move to GET_CH on 'S' or 'G' and SHALL queue response 'E'(0x45) on any other byte.
REQ-015 GET_CH SHALL queue 'E' when ch >= NUM_CHANNELS, SHALL go to GET_DUTY for 'S', and SHALL queue the channel's active duty byte for 'G'.
REQ-016 In GET_DUTY, the received byte SHALL be written to channel ch's pending-duty register and 'K'(0x4B) SHALL be queued.
REQ-017 RESP_WAIT SHALL wait while snd_busy is high; in the first cycle with snd_busy low it SHALL go to RESP_SEND.
REQ-018 RESP_SEND SHALL pulse snd_ready for exactly one cycle with snd_data valid, then return to IDLE.
REQ-019 Bytes with rcv_ready high while in RESP_WAIT or RESP_SEND SHALL be discarded without a response.
REQ-020 A prescaler SHALL count 0..PRESCALE-1, and on its terminal count an 8-bit phase counter SHALL increment, wrapping 255->0.
REQ-021 pwm[i] SHALL be registered and SHALL be high exactly when phase < active_duty[i].
REQ-022 Duty 0 SHALL give a constant low output, and duty 255 SHALL give high for 255 of 256 phase steps.
REQ-023 active_duty[i] SHALL load from the pending-duty register only on the cycle the phase wraps 255->0, so no period is ever truncated.
REQ-024 If a pending write and a phase wrap occur in the same cycle, the newly written value SHALL be loaded at that wrap.
REQ-025 A 'G' command SHALL return active_duty, not pending_duty.
REQ-026 Latency SHALL be as follows: with snd_busy low, snd_ready rises 2 cycles after the rcv_ready pulse of the final command byte.

Reset
REQ-027 While reset is low, the FSM SHALL be in IDLE and snd_ready, snd_data, pwm, the prescaler, the phase counter and all duty registers SHALL be 0.
REQ-028 Assertion of reset SHALL take effect immediately, including mid-command and mid-response, and any queued response SHALL be lost.
REQ-029 Release of reset SHALL be followed by normal operation from the next rising clock edge.

Configuration
REQ-030 With macro UART_PWM_CMD_TIMEOUT_EN defined, an idle counter SHALL clear on every rcv_ready and SHALL count while in GET_CH or GET_DUTY.
REQ-031 With UART_PWM_CMD_TIMEOUT_EN defined, the FSM SHALL return to IDLE with no response when the idle count reaches TIMEOUT_CYCLES.
REQ-032 With UART_PWM_CMD_TIMEOUT_EN undefined, no idle counter SHALL exist and a partial command SHALL wait indefinitely.

Verification
REQ-033 The bench SHALL cover: 'S',1,0x80 -> 'K' sent; pwm[1] high for 128 of 256 phase steps, starting at the next phase wrap.
REQ-034 The bench SHALL cover: 'G',1 after the above and after a wrap -> snd_data=0x80 with one snd_ready pulse.
REQ-035 The bench SHALL cover: 'S',3,0x10 with NUM_CHANNELS=3 -> 'E' sent after the ch byte; the 0x10 byte is treated as a fresh command -> second 'E'.
REQ-036 The bench SHALL cover: snd_busy held high for 100 cycles during a response -> snd_ready stays low and pulses once within 1 cycle of busy falling; a byte received meanwhile produces no response.
REQ-037 The bench SHALL cover: duties 0 and 255 -> pwm constant low, and pwm low for exactly 1 phase step per period, respectively.
REQ-038 The bench SHALL cover, with UART_PWM_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=50: 'S' then silence for 60 cycles, then 'G',0 -> only the duty byte is returned; also reset asserted mid-'S' -> all outputs 0 immediately.
